// File: rtl/accumulatore_z_pkg.sv
// Shared types and constants for the accumulatore_z sample accumulator.
package accumulatore_z_pkg;
  localparam int Z_W       = 3;
  localparam int OUT_W     = 8;
  localparam int LOG2N_MAX = 5;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACC_HOLD = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_CLR  = 2'd2
  } acc_cmd_t;

  typedef struct packed {
    acc_cmd_t acc;
    logic     rfd_set;
    logic     rfd_clr;
    logic     dav_assert;
    logic     dav_release;
    logic     out_ld;
  } cmd_t;
endpackage

// File: rtl/accumulatore_z_if.sv
// Sample-in / result-out handshake bundle; slave is the accumulator side.
interface accumulatore_z_if;
  import accumulatore_z_pkg::*;
  logic [Z_W-1:0]   z;
  logic             dav_in_;
  logic             rfd_in;
  logic [OUT_W-1:0] out;
  logic             dav_out_;
  logic             rfd_out;

  modport master (output z, dav_in_, rfd_out, input rfd_in, out, dav_out_);
  modport slave  (input z, dav_in_, rfd_out, output rfd_in, out, dav_out_);
endinterface

// File: rtl/accumulatore_z_pc.sv
// Control part: owns the state register and decodes the datapath commands.
module accumulatore_z_pc
  import accumulatore_z_pkg::*;
(
  input  logic clock,
  input  logic reset_,
  input  logic c0_i,
  input  logic dav_in_i,
  input  logic rfd_out_i,
  output cmd_t cmd_o
);
  state_t star_q;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) star_q <= S0;
    else begin
      case (star_q)
        S0: if (!dav_in_i) star_q <= S1;
        S1: if (dav_in_i) star_q <= c0_i ? S2 : S0;
        S2: star_q <= S3;
        S3: if (!rfd_out_i) star_q <= S4;
        S4: if (rfd_out_i) star_q <= S0;
        default: star_q <= S0;
      endcase
    end
  end

  // Illegal codes issue no commands, so recovery to S0 leaves registers untouched.
  always_comb begin
    cmd_o = '0;
    case (star_q)
      S0: if (!dav_in_i) begin
        cmd_o.acc     = ACC_ADD;
        cmd_o.rfd_clr = 1'b1;
      end
      S1: if (dav_in_i) cmd_o.rfd_set = 1'b1;
      S2: begin
        cmd_o.out_ld     = 1'b1;
        cmd_o.dav_assert = 1'b1;
      end
      S3: if (!rfd_out_i) cmd_o.dav_release = 1'b1;
      S4: if (rfd_out_i) cmd_o.acc = ACC_CLR;
      default: ;
    endcase
  end
endmodule

// File: rtl/accumulatore_z.sv
// Accumulates 2**LOG2N samples of z and hands the result downstream.
// Define ACCUMULATORE_Z_MEAN_EN to present the truncating mean instead of the sum.
module accumulatore_z
  import accumulatore_z_pkg::*;
#(
  parameter int LOG2N = 2
) (
  input logic              clock,
  input logic              reset_,
  accumulatore_z_if.slave  bus
);
  localparam int            CW = LOG2N + 1;
  localparam logic [CW-1:0] N  = CW'(2**LOG2N);

  logic [OUT_W-1:0] sum_q, sum_d, out_q, out_d, result;
  logic [CW-1:0]    count_q, count_d;
  logic             rfd_q, rfd_d, dav_q, dav_d;
  logic             c0;
  cmd_t             cmd;

  assign c0 = (count_q == N);

  accumulatore_z_pc u_pc (
    .clock     (clock),
    .reset_    (reset_),
    .c0_i      (c0),
    .dav_in_i  (bus.dav_in_),
    .rfd_out_i (bus.rfd_out),
    .cmd_o     (cmd)
  );

`ifdef ACCUMULATORE_Z_MEAN_EN
  assign result = sum_q >> LOG2N;
`else
  assign result = sum_q;
`endif

  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    case (cmd.acc)
      ACC_ADD: begin
        sum_d   = sum_q + OUT_W'(bus.z);
        count_d = count_q + CW'(1);
      end
      ACC_CLR: begin
        sum_d   = '0;
        count_d = '0;
      end
      default: ;
    endcase
    out_d = cmd.out_ld ? result : out_q;
    rfd_d = cmd.rfd_clr ? 1'b0 : (cmd.rfd_set ? 1'b1 : rfd_q);
    dav_d = cmd.dav_assert ? 1'b0 : (cmd.dav_release ? 1'b1 : dav_q);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sum_q   <= '0;
      count_q <= '0;
      out_q   <= '0;
      rfd_q   <= 1'b1;
      dav_q   <= 1'b1;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      out_q   <= out_d;
      rfd_q   <= rfd_d;
      dav_q   <= dav_d;
    end
  end

  assign bus.rfd_in   = rfd_q;
  assign bus.dav_out_ = dav_q;
  assign bus.out      = out_q;
endmodule

// File: tb/tb_accumulatore_z.sv
// Randomized self-checking bench for accumulatore_z (LOG2N=2 and LOG2N=5 instances).
`timescale 1ns/1ps
module tb_accumulatore_z;
  import accumulatore_z_pkg::*;

`ifdef ACCUMULATORE_Z_MEAN_EN
  localparam bit MEAN_EN = 1'b1;
`else
  localparam bit MEAN_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_;
  int   n_chk  = 0;
  int   n_fail = 0;

  accumulatore_z_if bus2();
  accumulatore_z_if bus5();

  accumulatore_z #(.LOG2N(2)) dut2 (.clock(clock), .reset_(reset_), .bus(bus2));
  accumulatore_z #(.LOG2N(5)) dut5 (.clock(clock), .reset_(reset_), .bus(bus5));

  always #5 clock = ~clock;

  // Reference: the result is the plain sum of the group, or its floor mean.
  function automatic int model(input int s[$], input int log2n);
    int acc = 0;
    foreach (s[i]) acc += s[i];
    return MEAN_EN ? (acc >> log2n) : acc;
  endfunction

  task automatic send2(input int zv, output int cyc, output bit ok);
    int n = 0;
    bus2.z       = zv[2:0];
    bus2.dav_in_ = 1'b0;
    do begin @(negedge clock); n++; end while (bus2.rfd_in !== 1'b0 && n < 50);
    ok = (bus2.rfd_in === 1'b0);
    bus2.dav_in_ = 1'b1;
    do begin @(negedge clock); n++; end while (bus2.rfd_in !== 1'b1 && n < 100);
    ok  = ok && (bus2.rfd_in === 1'b1);
    cyc = n;
  endtask

  task automatic wait_dav2(output int n, output bit ok);
    n = 0;
    do begin @(negedge clock); n++; end while (bus2.dav_out_ !== 1'b0 && n < 100);
    ok = (bus2.dav_out_ === 1'b0);
  endtask

  task automatic recv2(output logic [7:0] val, output bit ok);
    int  n;
    bit  ok1;
    wait_dav2(n, ok1);
    val = bus2.out;
    bus2.rfd_out = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (bus2.dav_out_ !== 1'b1 && n < 50);
    ok = ok1 && (bus2.dav_out_ === 1'b1);
    bus2.rfd_out = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_group2(input int s[$], output bit ok);
    int cyc;
    bit ok1;
    ok = 1'b1;
    foreach (s[i]) begin
      send2(s[i], cyc, ok1);
      ok = ok && ok1;
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    bus2.z = 3'd7; bus2.dav_in_ = 1'b0; bus2.rfd_out = 1'b0;
    bus5.z = 3'd7; bus5.dav_in_ = 1'b0; bus5.rfd_out = 1'b0;
    repeat (3) @(negedge clock);
    n_chk++; if (bus2.rfd_in !== 1'b1) begin n_fail++; $display("FAIL reset_rfd_in: got %b expected 1", bus2.rfd_in); end
    n_chk++; if (bus2.dav_out_ !== 1'b1) begin n_fail++; $display("FAIL reset_dav_out: got %b expected 1", bus2.dav_out_); end
    n_chk++; if (bus2.out !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", bus2.out); end
    n_chk++; if (bus5.rfd_in !== 1'b1 || bus5.dav_out_ !== 1'b1 || bus5.out !== 8'd0) begin
      n_fail++; $display("FAIL reset_dut5: got rfd=%b dav=%b out=%0d expected 1 1 0", bus5.rfd_in, bus5.dav_out_, bus5.out);
    end
    bus2.dav_in_ = 1'b1; bus2.rfd_out = 1'b1;
    bus5.dav_in_ = 1'b1; bus5.rfd_out = 1'b1;
    reset_ = 1'b1;
    @(negedge clock);
    n_chk++; if (bus2.rfd_in !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got rfd_in=%b expected 1", bus2.rfd_in); end
  endtask

  task automatic test_basic();
    int vals[4] = '{3, 5, 7, 1};
    int s[$];
    int cyc, n, tot = 0, low = 0;
    bit ok, allok = 1'b1;
    foreach (vals[i]) s.push_back(vals[i]);
    bus2.rfd_out = 1'b0;
    foreach (s[i]) begin send2(s[i], cyc, ok); tot += cyc; allok = allok && ok; end
    wait_dav2(n, ok);
    tot += n; allok = allok && ok;
    n_chk++; if (!allok) begin n_fail++; $display("FAIL basic_handshake: got timeout expected all acks"); end
    n_chk++; if (tot != 9) begin n_fail++; $display("FAIL basic_latency: got %0d clocks expected 9", tot); end
    n_chk++; if (bus2.out !== 8'(model(s, 2))) begin n_fail++; $display("FAIL basic_out: got %0d expected %0d", bus2.out, model(s, 2)); end
    while (bus2.dav_out_ === 1'b0 && low < 20) begin @(negedge clock); low++; end
    n_chk++; if (low != 1) begin n_fail++; $display("FAIL basic_dav_width: got %0d clocks expected 1", low); end
    bus2.rfd_out = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_random();
    int s[$];
    logic [7:0] val;
    bit ok1, ok2;
    for (int g = 0; g < 4; g++) begin
      s.delete();
      for (int i = 0; i < 4; i++) s.push_back(int'($urandom_range(0, 7)));
      send_group2(s, ok1);
      recv2(val, ok2);
      n_chk++; if (!(ok1 && ok2) || val !== 8'(model(s, 2))) begin
        n_fail++; $display("FAIL random_group%0d: got %0d ok=%b expected %0d", g, val, ok1 && ok2, model(s, 2));
      end
    end
  endtask

  task automatic test_hold_dav();
    int s[$];
    int n = 0, bad = 0;
    logic [7:0] val;
    bit ok1, ok2;
    s.push_back(2); s.push_back(1); s.push_back(1); s.push_back(1);
    bus2.z = 3'd2; bus2.dav_in_ = 1'b0;
    do begin @(negedge clock); n++; end while (bus2.rfd_in !== 1'b0 && n < 50);
    bus2.z = 3'd7;
    repeat (10) begin @(negedge clock); if (bus2.rfd_in !== 1'b0) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL hold_rfd_low: got %0d high clocks expected 0", bad); end
    bus2.dav_in_ = 1'b1;
    @(negedge clock);
    s.delete(0);
    send_group2(s, ok1);
    s.push_front(2);
    recv2(val, ok2);
    n_chk++; if (!(ok1 && ok2) || val !== 8'(model(s, 2))) begin
      n_fail++; $display("FAIL hold_single_sample: got %0d expected %0d", val, model(s, 2));
    end
  endtask

  task automatic test_slow_downstream();
    int g1[$], g2[$];
    int n, bad = 0;
    logic [7:0] held, val;
    bit ok1, ok2;
    for (int i = 0; i < 4; i++) begin
      g1.push_back(int'($urandom_range(0, 7)));
      g2.push_back(int'($urandom_range(0, 7)));
    end
    bus2.rfd_out = 1'b1;
    send_group2(g1, ok1);
    wait_dav2(n, ok2);
    held = bus2.out;
    n_chk++; if (!(ok1 && ok2) || held !== 8'(model(g1, 2))) begin
      n_fail++; $display("FAIL slow_out: got %0d expected %0d", held, model(g1, 2));
    end
    bus2.z = g2[0][2:0]; bus2.dav_in_ = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (bus2.dav_out_ !== 1'b0 || bus2.out !== held || bus2.rfd_in !== 1'b1) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL slow_hold: got %0d bad clocks expected 0", bad); end
    bus2.rfd_out = 1'b0;
    @(negedge clock);
    n_chk++; if (bus2.dav_out_ !== 1'b1 || bus2.rfd_in !== 1'b1) begin
      n_fail++; $display("FAIL slow_s4: got dav=%b rfd=%b expected 1 1", bus2.dav_out_, bus2.rfd_in);
    end
    bus2.rfd_out = 1'b1;
    @(negedge clock);
    n_chk++; if (bus2.rfd_in !== 1'b1) begin n_fail++; $display("FAIL slow_s4_exit: got rfd=%b expected 1", bus2.rfd_in); end
    @(negedge clock);
    n_chk++; if (bus2.rfd_in !== 1'b0) begin n_fail++; $display("FAIL slow_next_ack: got rfd=%b expected 0", bus2.rfd_in); end
    bus2.dav_in_ = 1'b1;
    @(negedge clock);
    for (int i = 1; i < 4; i++) begin send2(g2[i], n, ok1); ok2 = ok2 && ok1; end
    recv2(val, ok1);
    n_chk++; if (!(ok1 && ok2) || val !== 8'(model(g2, 2))) begin
      n_fail++; $display("FAIL slow_next_group: got %0d expected %0d", val, model(g2, 2));
    end
  endtask

  task automatic test_reset_mid();
    int g[$], p[$], ones[$];
    int n = 0;
    logic [7:0] val;
    bit ok1, ok2;
    for (int i = 0; i < 4; i++) begin g.push_back(int'($urandom_range(1, 7))); ones.push_back(1); end
    p.push_back(4); p.push_back(5);
    bus2.rfd_out = 1'b1;
    send_group2(g, ok1);
    wait_dav2(n, ok2);
    #2 reset_ = 1'b0;
    #1;
    n_chk++; if (bus2.dav_out_ !== 1'b1 || bus2.out !== 8'd0 || bus2.rfd_in !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: got dav=%b out=%0d rfd=%b expected 1 0 1", bus2.dav_out_, bus2.out, bus2.rfd_in);
    end
    @(negedge clock);
    reset_ = 1'b1;
    send_group2(p, ok1);
    bus2.z = 3'd3; bus2.dav_in_ = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (bus2.rfd_in !== 1'b0 && n < 50);
    #2 reset_ = 1'b0;
    #1;
    n_chk++; if (bus2.rfd_in !== 1'b1) begin n_fail++; $display("FAIL rstmid_rfd: got %b expected 1", bus2.rfd_in); end
    bus2.dav_in_ = 1'b1;
    @(negedge clock);
    reset_ = 1'b1;
    send_group2(ones, ok1);
    recv2(val, ok2);
    n_chk++; if (!(ok1 && ok2) || val !== 8'(model(ones, 2))) begin
      n_fail++; $display("FAIL rstmid_fresh_group: got %0d expected %0d", val, model(ones, 2));
    end
  endtask

  task automatic test_max();
    int s[$];
    int n, tot = 0;
    bit ok = 1'b1;
    bus5.rfd_out = 1'b0;
    for (int i = 0; i < 32; i++) begin
      s.push_back(7);
      bus5.z = 3'd7; bus5.dav_in_ = 1'b0;
      n = 0;
      do begin @(negedge clock); n++; end while (bus5.rfd_in !== 1'b0 && n < 50);
      ok = ok && (bus5.rfd_in === 1'b0);
      tot += n;
      bus5.dav_in_ = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (bus5.rfd_in !== 1'b1 && n < 50);
      ok = ok && (bus5.rfd_in === 1'b1);
      tot += n;
    end
    n = 0;
    do begin @(negedge clock); n++; end while (bus5.dav_out_ !== 1'b0 && n < 100);
    tot += n;
    n_chk++; if (!ok || bus5.dav_out_ !== 1'b0) begin n_fail++; $display("FAIL max_handshake: got timeout expected acks"); end
    n_chk++; if (tot != 65) begin n_fail++; $display("FAIL max_latency: got %0d clocks expected 65", tot); end
    n_chk++; if (bus5.out !== 8'(model(s, 5))) begin n_fail++; $display("FAIL max_out: got %0d expected %0d", bus5.out, model(s, 5)); end
    @(negedge clock);
    bus5.rfd_out = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_hold_dav();
    test_slow_downstream();
    test_reset_mid();
    test_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/accumulatore_z.md
# accumulatore_z

Downstream consumer of the 3-bit `z` output of the RSS stage. Samples `z` over an input dav_/rfd handshake and accumulates `N = 2**LOG2N` samples into an 8-bit sum. It then presents the result to the next stage over an output dav_/rfd handshake. Controller and datapath are specified as one unit; the control part is split into a sub-module.

## Interface
- `LOG2N`, default 2: log2 of the samples per result; legal range 0..5, so N is 1..32.
- `clock`  in  1  system clock, rising edge active.
- `reset_`  in  1  reset, asynchronous and active-low.
- `z`  in  3  sample from the upstream RSS.
- `dav_in_`  in  1  upstream data-available, active-low.
- `rfd_in`  out  1  ready-for-data to upstream, active-high.
- `out`  out  8  result (sum, or mean when `MEAN_EN` is defined).
- `dav_out_`  out  1  result-available to downstream, active-low.
- `rfd_out`  in  1  downstream ready-for-data, active-high.

## Operation
- Registers:
  - `SUM[7:0]`
  - `COUNT[LOG2N:0]`
  - `OUT[7:0]`, driving `out`
  - `RFD`, driving `rfd_in`
  - `DAV_OUT`, driving `dav_out_`
  - `STAR[2:0]`
- Reset (`reset_==0`, asynchronous) sets:
  - `SUM=0`, `COUNT=0`, `OUT=0`
  - `RFD=1`, `DAV_OUT=1`
  - `STAR=S0`
- S0 (wait input):
  - If `dav_in_==0`: `SUM<=SUM+z` (z zero-extended), `COUNT<=COUNT+1`, `RFD<=0`, go to S1.
  - Otherwise hold.
- S1 (wait input release):
  - If `dav_in_==1`: `RFD<=1`, then go to S2 if `COUNT==N`, else S0.
  - Otherwise hold with `RFD=0`.
- S2 (present): `OUT<=SUM`, `DAV_OUT<=0`, go to S3. No wait condition.
- S3 (wait accept):
  - If `rfd_out==0`: `DAV_OUT<=1`, go to S4.
  - Otherwise hold.
- S4 (wait downstream ready):
  - If `rfd_out==1`: `SUM<=0`, `COUNT<=0`, go to S0.
  - Otherwise hold.
- Codes 5..7 of `STAR` are unreachable. If one is entered, the next edge goes to S0 with no register update.
- Arithmetic:
  - Unsigned.
  - Maximum sum is 7·32=224, so the 8-bit `SUM` never overflows.
  - `COUNT` reaches exactly N and never wraps.
- Input is ignored outside S0: `z` changes while in S1..S4 have no effect.
- Handshake rules:
  - Upstream may change `z` only while `dav_in_==1`.
  - Upstream must hold `dav_in_==0` until `rfd_in==0` is seen.
- `out` stays stable from S2 until the next S2.

## Timing
- One sample accepted per handshake. Minimum 2 clocks per sample: S0→S1 on the `dav_in_` falling edge, S1→S0 on its rise.
- `rfd_in` falls on the first rising clock edge that samples `dav_in_==0` in S0.
- Latency from the edge that releases the N-th sample (S1→S2) to `dav_out_==0`: 1 clock.
- Minimum period per result with immediate partners: 2N + 3 clocks.
- If `rfd_out` is already 0 when S3 is entered, `dav_out_` rises on the next edge; it is low for exactly 1 clock.
- Reset mid-operation:
  - Partial sum is discarded.
  - `rfd_in=1` and `dav_out_=1` within the same time step as `reset_` falling; no clock needed.
  - `out` is cleared to 0.
- After `reset_` rises, the first active edge evaluates S0.

## Configuration
- `ACCUMULATORE_Z_MEAN_EN`:
  - Defined: S2 loads `OUT<=SUM>>LOG2N`, the truncating mean, 0..7, zero-extended.
  - Undefined: S2 loads the raw `SUM`.
- Nothing else changes: state sequence, timing and reset values are identical in both builds.

## Structure
- Shared package holds:
  - state encodings `S0..S4` (0..4)
  - width constants `Z_W=3`, `OUT_W=8`
  - the `LOG2N` legal-range limit
- Sub-module `accumulatore_z_pc` is the control part:
  - Owns `STAR`.
  - Takes condition variables `c0 = (COUNT==N)`, `dav_in_`, `rfd_out`.
  - Drives command variables selecting the `SUM`/`COUNT` multiplexers: add, hold, clear.
  - Drives the `RFD`/`DAV_OUT` set/clear commands.
- The top holds the operative part: registers, adder, comparator and the optional shift.

## Test plan
- Reset held with `dav_in_=0`, `rfd_out=0` → `rfd_in=1`, `dav_out_=1`, `out=0`; no accumulation until `reset_` rises.
- LOG2N=2, samples 3,5,7,1 with immediate partner responses → `out=16`, `dav_out_` low 1 clock; cycle count from first `dav_in_` fall to `dav_out_` fall equals 2N+1 = 9.
- LOG2N=5, all 32 samples = 7 → `out=224`, no wrap; with `ACCUMULATORE_Z_MEAN_EN`, `out=7`.
- Upstream holds `dav_in_=0` for 10 clocks after `rfd_in` falls → exactly one sample added, `rfd_in` stays 0 until `dav_in_` rises.
- Downstream delays `rfd_out=0` by 6 clocks after `dav_out_` falls → `dav_out_` stays 0 and `out` stays stable; upstream's next `dav_in_=0` is not acknowledged (`rfd_in` stays 1) until S4 exits.
- `reset_` pulsed after 2 of 4 samples (sum 9) → next complete group 1,1,1,1 yields `out=4`, not 13.
